// File: rtl/mcu_pkg.sv
// Shared MCU definitions: datapath widths and the program-loader state set.
package mcu_pkg;

  localparam int INSTR_W = 12;
  localparam int ADDR_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } ld_state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: assembles 12-bit instructions from a byte stream (low byte,
// then high nibble), writes them to program memory one per WRITE cycle, and
// closes the image with an XOR checksum byte.
module program_loader
  import mcu_pkg::*;
#(
  parameter int PROG_LEN = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               PMem_LE,
  output logic [ADDR_W-1:0]  load_addr,
  output logic [INSTR_W-1:0] load_instr,
  output logic               load_done,
  output logic               load_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  ld_state_t  state, state_nxt;
  logic [7:0] lo_byte;
  logic [7:0] checksum;
  logic       accept;

  // State register; reset parks the loader in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and state-decoded outputs; start always wins over a byte
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    PMem_LE   = 1'b0;
    load_done = 1'b0;
    load_err  = 1'b0;
    accept    = 1'b0;
    case (state)
      LO, HI, CHECK: rx_ready = !start;
      WRITE:         PMem_LE  = 1'b1;
      DONE:          load_done = 1'b1;
      ERR:           load_err  = 1'b1;
      default:       ;
    endcase
    accept = rx_valid && rx_ready;
    if (start) begin
      state_nxt = LO;
    end else begin
      case (state)
        LO:      if (accept) state_nxt = HI;
        HI:      if (accept) state_nxt = (rx_data[7:4] == 4'h0) ? WRITE : ERR;
        WRITE:   state_nxt = (load_addr == LAST_ADDR) ? CHECK : LO;
        CHECK:   if (accept) state_nxt = (rx_data == checksum) ? DONE : ERR;
        default: ;
      endcase
    end
  end

  // Byte assembly, running checksum and write address; the address is
  // compared before incrementing so it can never wrap past the last slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_byte    <= '0;
      checksum   <= '0;
      load_addr  <= '0;
      load_instr <= '0;
    end else if (start) begin
      checksum  <= '0;
      load_addr <= '0;
    end else begin
      case (state)
        LO: if (accept) begin
          lo_byte  <= rx_data;
          checksum <= checksum ^ rx_data;
        end
        HI: if (accept) begin
          checksum <= checksum ^ rx_data;
          if (rx_data[7:4] == 4'h0) load_instr <= {rx_data[3:0], lo_byte};
        end
        WRITE: if (load_addr != LAST_ADDR) load_addr <= load_addr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (PROG_LEN=2): a reference model turns
// each byte image into expected write/done/err events; a monitor pops and
// compares whenever the DUT shows one.
module tb_program_loader;

  localparam int PL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready, PMem_LE, load_done, load_err;
  logic [7:0]  load_addr;
  logic [11:0] load_instr;

  program_loader #(.PROG_LEN(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .PMem_LE(PMem_LE), .load_addr(load_addr),
    .load_instr(load_instr), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 write, 1 done, 2 err
    logic [7:0]  addr;
    logic [11:0] instr;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic pd = 1'b0, pe = 1'b0;

  // Image semantics: pairs of (lo, hi) bytes, hi upper nibble must be zero,
  // then one checksum byte equal to the XOR of all pair bytes.
  function automatic int model(input logic [7:0] b[$]);
    int used = 0;
    logic [7:0] ck = '0;
    ev_t e;
    for (int a = 0; a < PL; a++) begin
      if (used + 1 >= b.size()) return b.size();
      ck ^= b[used] ^ b[used+1];
      if (b[used+1][7:4] != 4'h0) begin
        e = '{kind: 2'd2, addr: 8'd0, instr: 12'd0};
        exp_q.push_back(e);
        return used + 2;
      end
      e = '{kind: 2'd0, addr: 8'(a), instr: {b[used+1][3:0], b[used]}};
      exp_q.push_back(e);
      used += 2;
    end
    if (used >= b.size()) return used;
    e = '{kind: (b[used] == ck) ? 2'd1 : 2'd2, addr: 8'd0, instr: 12'd0};
    exp_q.push_back(e);
    return used + 1;
  endfunction

  task automatic check_ev(input logic [1:0] k, input logic [7:0] a, input logic [11:0] i);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d instr=%03h, expected none", k, a, i);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == 2'd0 && (e.addr != a || e.instr != i))) begin
        errors++;
        $display("FAIL event: got kind=%0d addr=%0d instr=%03h, expected kind=%0d addr=%0d instr=%03h",
                 k, a, i, e.kind, e.addr, e.instr);
      end
    end
  endtask

  // Monitor: compare every write strobe and every rise of done/err
  always @(negedge clk) begin
    if (!rst) begin
      if (PMem_LE) check_ev(2'd0, load_addr, load_instr);
      if (load_done && !pd) check_ev(2'd1, 8'd0, 12'd0);
      if (load_err && !pe) check_ev(2'd2, 8'd0, 12'd0);
    end
    pd <= load_done;
    pe <= load_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // All driving happens 1 time unit after a rising edge
  task automatic do_start();
    rx_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_addr", 32'(load_addr), 0);
    chk("start_done", 32'(load_done), 0);
    chk("start_err", 32'(load_err), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    int n = 0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!acc && n < 40) begin
      #1 acc = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL byte_accept: byte %02h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_img(input logic [7:0] b[$], input int maxgap);
    int used;
    used = model(b);
    for (int k = 0; k < used; k++) send_byte(b[k], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    chk(name, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] img[$];
    logic [7:0] ck;
    #1;
    // Reset state
    chk("rst_ready", 32'(rx_ready), 0);
    chk("rst_le", 32'(PMem_LE), 0);
    chk("rst_addr", 32'(load_addr), 0);
    chk("rst_instr", 32'(load_instr), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_err", 32'(load_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // IDLE ignores the byte stream
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) begin #1 chk("idle_ready", 32'(rx_ready), 0); @(posedge clk); #1; end
    rx_valid = 1'b0;

    // Good image
    do_start();
    img = '{8'hA5, 8'h02, 8'hF0, 8'h00, 8'h57};
    send_img(img, 0);
    drain("good_drain");
    chk("good_done", 32'(load_done), 1);
    chk("good_err", 32'(load_err), 0);
    chk("good_instr_hold", 32'(load_instr), 32'h0F0);

    // Bad checksum
    do_start();
    img = '{8'hA5, 8'h02, 8'hF0, 8'h00, 8'h58};
    send_img(img, 0);
    drain("badck_drain");
    chk("badck_done", 32'(load_done), 0);
    chk("badck_err", 32'(load_err), 1);

    // Bad high nibble: error with no write
    do_start();
    img = '{8'hA5, 8'h12};
    send_img(img, 0);
    drain("badhi_drain");
    chk("badhi_err", 32'(load_err), 1);
    chk("badhi_instr_hold", 32'(load_instr), 32'h0F0);

    // Asynchronous reset mid-load, after the first write
    do_start();
    img = '{8'hA5, 8'h02, 8'hF0};
    send_img(img, 0);
    drain("mid_drain");
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(rx_ready), 0);
    chk("arst_le", 32'(PMem_LE), 0);
    chk("arst_addr", 32'(load_addr), 0);
    chk("arst_instr", 32'(load_instr), 0);
    chk("arst_done", 32'(load_done), 0);
    chk("arst_err", 32'(load_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_start();
    img = '{8'hA5, 8'h02, 8'hF0, 8'h00, 8'h57};
    send_img(img, 0);
    drain("post_rst_drain");
    chk("post_rst_done", 32'(load_done), 1);

    // start coinciding with a HI byte: start wins, byte dropped
    do_start();
    send_byte(8'hA5, 0);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
    #1 chk("coinc_ready", 32'(rx_ready), 0);
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    chk("coinc_addr", 32'(load_addr), 0);
    chk("coinc_done", 32'(load_done), 0);
    img = '{8'hA5, 8'h02, 8'hF0, 8'h00, 8'h57};
    send_img(img, 0);
    drain("coinc_drain");
    chk("coinc_final_done", 32'(load_done), 1);

    // Random images, each run with random gaps and then back-to-back
    for (int it = 0; it < 10; it++) begin
      img = {};
      ck = '0;
      for (int k = 0; k < PL; k++) begin
        logic [7:0] lo, hi;
        lo = 8'($urandom);
        hi = ($urandom_range(0, 7) == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)} : {4'h0, 4'($urandom)};
        img.push_back(lo); img.push_back(hi);
        ck ^= lo ^ hi;
      end
      img.push_back(($urandom_range(0, 3) == 0) ? (ck ^ 8'($urandom_range(1, 255))) : ck);
      do_start();
      send_img(img, 5);
      drain("rand_gap_drain");
      do_start();
      send_img(img, 0);
      drain("rand_b2b_drain");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
